l2_port_scheduler: RTL
======================

Name: l2_port_scheduler

Overview:
- Owns the single L1D-to-L2 port and shares it between two requesters:
  - L1D read-miss refills (ReadData path).
  - Dirty-victim drains from a DEPTH-entry write buffer whose address/slot queue lives in this block.
- Enforces read-after-write ordering: a refill never bypasses a buffered victim with the same block address.
- Sits between the L1D cache controller and L2. Data RAMs stay outside; this block supplies the slot index.

Parameters:
- DEPTH, 4, write-buffer entries (power of 2, ≥2).
- AW, 27, block-address width (21-bit tag + 6-bit index).
- PW, 2, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- wb_push  in  1  L1D enqueues a dirty victim this cycle.
- wb_addr  in  AW  victim block address.
- wb_full  out  1  buffer full (count==DEPTH), registered.
- wb_empty  out  1  count==0, registered.
- wb_slot  out  PW  slot written by the current push (tail pointer).
- rd_req  in  1  L1D refill request, held until rd_done.
- rd_addr  in  AW  refill block address, stable while rd_req=1.
- rd_done  out  1  one-cycle pulse: refill data delivered.
- l2_req  out  1  L2 transaction active.
- l2_we  out  1  1 = write-back, 0 = refill read.
- l2_addr  out  AW  L2 block address.
- l2_slot  out  PW  buffer slot being drained (valid when l2_we=1).
- l2_ack  in  1  L2 completion, one cycle, only while l2_req=1.
- ovf_err  out  1  sticky: push attempted while full.

Behaviour:
- Reset (reset=0 at posedge): state IDLE, head=tail=count=0.
  - Outputs after reset: l2_req=0, l2_we=0, l2_addr=0, l2_slot=0, rd_done=0, wb_full=0, wb_empty=1, ovf_err=0.
  - Reset mid-transaction aborts it and discards all buffer entries.
- All outputs registered except wb_slot, which equals tail.
- Push:
  - When wb_push=1 and wb_full=0: store wb_addr at tail, tail++ (mod DEPTH), count++.
  - Push while full: ignored, ovf_err<=1.
- Hazard: rd_req=1 and rd_addr equals any valid entry, or equals wb_addr during a same-cycle accepted push.
- FSM states IDLE, RD, WB.
  - IDLE, rd_done=1 this cycle: no grant (stale rd_req).
  - IDLE, rd_req=1 and no hazard: go to RD, l2_req<=1, l2_we<=0, l2_addr<=rd_addr.
  - IDLE, rd_req=1 with hazard: go to WB (drain head); repeat drains until the hazard clears.
  - IDLE, rd_req=0 and count>0: go to WB, l2_req<=1, l2_we<=1, l2_addr<=entry[head], l2_slot<=head.
  - IDLE otherwise: stay.
  - RD: hold outputs; on l2_ack go to IDLE, l2_req<=0, rd_done<=1 for exactly one cycle.
  - WB: hold outputs; on l2_ack pop head (head++, count--), l2_req<=0, go to IDLE.
- Priority: refill beats drain unless there is a hazard. Grant decision to l2_req=1 takes 1 cycle.
- Simultaneous push and pop: count unchanged; wb_full reflects the registered count, so a push in the pop cycle of a full buffer is rejected.
- Pointers wrap modulo DEPTH.
- l2_ack outside RD/WB is ignored.
- Pushes are accepted in all states.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wb_push=1 → count stays 0, wb_empty=1, l2_req=0, ovf_err=0.
- Refill, empty buffer: rd_req=1, rd_addr=27'h000040 → next cycle l2_req=1, l2_we=0, l2_addr=27'h000040; ack after 8 cycles → rd_done=1 for one cycle, l2_req=0; no second grant while rd_req is still high in that cycle.
- Idle drain: push 27'h000C0 and 27'h00140 → two WB transactions in FIFO order, l2_slot=0 then 1; after both acks wb_empty=1.
- RAW hazard: buffer holds 27'h000C0 (slot 0), rd_req with rd_addr=27'h000C0 → WB of slot 0 first, then RD; rd_done only after the second ack.
- No hazard: buffer holds 27'h000C0, rd_addr=27'h00200 → RD granted first, drain follows.
- Full/overflow/wrap: push 4 entries → wb_full=1; a 5th push → ovf_err=1 and the entry is dropped; drain all, push 2 more → slots 0,1 (wrap), addresses correct.

Source files
------------

// File: rtl/l2_port_scheduler_if.sv
// rtl/l2_port_scheduler_if.sv - L1D/L2 port signals of the scheduler, grouped with directional modports.
interface l2_port_scheduler_if #(
    parameter int AW = 27,
    parameter int PW = 2
);
    logic          wb_push;
    logic [AW-1:0] wb_addr;
    logic          wb_full;
    logic          wb_empty;
    logic [PW-1:0] wb_slot;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_done;
    logic          l2_req;
    logic          l2_we;
    logic [AW-1:0] l2_addr;
    logic [PW-1:0] l2_slot;
    logic          l2_ack;
    logic          ovf_err;

    modport slave (
        input  wb_push, wb_addr, rd_req, rd_addr, l2_ack,
        output wb_full, wb_empty, wb_slot, rd_done, l2_req, l2_we, l2_addr, l2_slot, ovf_err
    );

    modport master (
        output wb_push, wb_addr, rd_req, rd_addr, l2_ack,
        input  wb_full, wb_empty, wb_slot, rd_done, l2_req, l2_we, l2_addr, l2_slot, ovf_err
    );
endinterface

// File: rtl/l2_port_scheduler.sv
// rtl/l2_port_scheduler.sv - L2 port arbiter between L1D refills and a victim write buffer with RAW ordering.
module l2_port_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 27,
    parameter int PW    = 2
) (
    input  logic                clk,
    input  logic                reset,
    l2_port_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WB} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          l2_req_q, l2_req_d;
    logic          l2_we_q, l2_we_d;
    logic [AW-1:0] l2_addr_q, l2_addr_d;
    logic [PW-1:0] l2_slot_q, l2_slot_d;
    logic          rd_done_q, rd_done_d;

    logic          push_acc;
    logic          pop;
    logic          hit;
    logic          hazard;
    logic [PW-1:0] rel;
    logic [AW-1:0] drain_addr;

    always_comb begin
        push_acc = bus.wb_push & ~full_q;
        pop      = (state_q == WB) & bus.l2_ack;

        // An entry is live when its distance from head is below the occupancy.
        hit = 1'b0;
        rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PW'(i) - head_q;
            if (({1'b0, rel} < count_q) && (mem_q[i] == bus.rd_addr)) begin
                hit = 1'b1;
            end
        end
        hazard = bus.rd_req & (hit | (push_acc & (bus.wb_addr == bus.rd_addr)));

        mem_d = mem_q;
        if (push_acc) begin
            mem_d[tail_q] = bus.wb_addr;
        end
        tail_d  = tail_q + PW'(push_acc);
        head_d  = head_q + PW'(pop);
        count_d = count_q + (PW+1)'(push_acc) - (PW+1)'(pop);
        full_d  = (count_d == (PW+1)'(DEPTH));
        empty_d = (count_d == '0);
        ovf_d   = ovf_q | (bus.wb_push & full_q);

        // With an empty buffer the only drainable entry is the one being pushed now.
        drain_addr = (count_q == '0) ? bus.wb_addr : mem_q[head_q];

        state_d   = state_q;
        l2_req_d  = l2_req_q;
        l2_we_d   = l2_we_q;
        l2_addr_d = l2_addr_q;
        l2_slot_d = l2_slot_q;
        rd_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rd_done_q) begin
                    if (bus.rd_req && !hazard) begin
                        state_d   = RD;
                        l2_req_d  = 1'b1;
                        l2_we_d   = 1'b0;
                        l2_addr_d = bus.rd_addr;
                    end else if (hazard || (count_q != '0)) begin
                        state_d   = WB;
                        l2_req_d  = 1'b1;
                        l2_we_d   = 1'b1;
                        l2_addr_d = drain_addr;
                        l2_slot_d = head_q;
                    end
                end
            end
            RD: begin
                if (bus.l2_ack) begin
                    state_d   = IDLE;
                    l2_req_d  = 1'b0;
                    rd_done_d = 1'b1;
                end
            end
            WB: begin
                if (bus.l2_ack) begin
                    state_d  = IDLE;
                    l2_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            l2_req_q  <= 1'b0;
            l2_we_q   <= 1'b0;
            l2_addr_q <= '0;
            l2_slot_q <= '0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            l2_req_q  <= l2_req_d;
            l2_we_q   <= l2_we_d;
            l2_addr_q <= l2_addr_d;
            l2_slot_q <= l2_slot_d;
            rd_done_q <= rd_done_d;
        end
    end

    assign bus.wb_full  = full_q;
    assign bus.wb_empty = empty_q;
    assign bus.wb_slot  = tail_q;
    assign bus.rd_done  = rd_done_q;
    assign bus.l2_req   = l2_req_q;
    assign bus.l2_we    = l2_we_q;
    assign bus.l2_addr  = l2_addr_q;
    assign bus.l2_slot  = l2_slot_q;
    assign bus.ovf_err  = ovf_q;
endmodule
